// File: rtl/calc_pkg.sv
// Shared key codes, FSM state encoding and key classification for the calculator sequencer.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_EQ  = 4'hB;
  localparam logic [3:0] KEY_CLR = 4'hC;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    SHOW    = 3'd4
  } calc_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_accum.sv
// Decimal operand register: value*10 + digit on each accepted digit, capped at DIGITS digits.
module digit_accum #(
  parameter int W      = 12,
  parameter int DIGITS = 3,
  parameter int CW     = $clog2(DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [W-1:0]  load_val_i,
  input  logic [CW-1:0] load_cnt_i,
  input  logic          digit_en_i,
  input  logic [3:0]    digit_i,
  output logic [W-1:0]  value_o
);

  logic [W-1:0]  value_q, value_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  digit_ext;

  assign digit_ext = {{(W-4){1'b0}}, digit_i};

  always_comb begin
    value_d = value_q;
    count_d = count_q;
    if (clr_i) begin
      value_d = '0;
      count_d = '0;
    end else if (load_i) begin
      value_d = load_val_i;
      count_d = load_cnt_i;
    end else if (digit_en_i && (count_q < CW'(DIGITS))) begin
      // x*10 as two shifts and an add; leading zeros still consume a digit slot
      value_d = (value_q << 3) + (value_q << 1) + digit_ext;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      count_q <= '0;
    end else begin
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad-driven sequencer for the 12-bit adder: builds A and B, pulses start, captures the sum.
// Define AUTO_CHAIN_EN to let '+' in SHOW reuse the result as the next operand A.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W       = 12,
  parameter int DIGITS  = 3,
  parameter int ADD_LAT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic [W:0]   resultado,
  output logic [W-1:0] num1,
  output logic [W-1:0] num2,
  output logic         suma_btn,
  output logic [W:0]   disp_value,
  output logic         busy,
  output logic         res_valid
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int LW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  calc_state_t  state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [W:0]   res_q, res_d;

  logic          a_clr, a_load, a_dig;
  logic [W-1:0]  a_load_val;
  logic [CW-1:0] a_load_cnt;
  logic          b_clr, b_dig;
  logic          key_digit, key_add, key_eq, key_clr;

  assign key_digit = key_valid && is_digit(key_code);
  assign key_add   = key_valid && (key_code == KEY_ADD);
  assign key_eq    = key_valid && (key_code == KEY_EQ);
  assign key_clr   = key_valid && (key_code == KEY_CLR);

  digit_accum #(.W(W), .DIGITS(DIGITS), .CW(CW)) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (a_clr),
    .load_i     (a_load),
    .load_val_i (a_load_val),
    .load_cnt_i (a_load_cnt),
    .digit_en_i (a_dig),
    .digit_i    (key_code),
    .value_o    (num1)
  );

  digit_accum #(.W(W), .DIGITS(DIGITS), .CW(CW)) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (b_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .load_cnt_i ('0),
    .digit_en_i (b_dig),
    .digit_i    (key_code),
    .value_o    (num2)
  );

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    res_d      = res_q;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_dig      = 1'b0;
    a_load_val = '0;
    a_load_cnt = '0;
    b_clr      = 1'b0;
    b_dig      = 1'b0;

    // Clear wins everywhere; an already issued start pulse simply goes unanswered
    if (key_clr) begin
      state_d = ENTER_A;
      lat_d   = '0;
      res_d   = '0;
      a_clr   = 1'b1;
      b_clr   = 1'b1;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (key_digit) begin
            a_dig = 1'b1;
          end else if (key_add) begin
            b_clr   = 1'b1;
            state_d = ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_digit) begin
            b_dig = 1'b1;
          end else if (key_eq) begin
            state_d = START;
          end
        end
        START: begin
          lat_d   = LW'(ADD_LAT - 1);
          state_d = WAIT;
        end
        WAIT: begin
          if (lat_q == '0) begin
            res_d   = resultado;
            state_d = SHOW;
          end else begin
            lat_d = lat_q - LW'(1);
          end
        end
        SHOW: begin
          if (key_digit) begin
            a_load     = 1'b1;
            a_load_val = {{(W-4){1'b0}}, key_code};
            a_load_cnt = CW'(1);
            b_clr      = 1'b1;
            state_d    = ENTER_A;
          end
`ifdef AUTO_CHAIN_EN
          else if (key_add) begin
            a_load     = 1'b1;
            a_load_val = res_q[W-1:0];
            a_load_cnt = '0;
            b_clr      = 1'b1;
            state_d    = ENTER_B;
          end
`endif
        end
        default: state_d = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTER_A;
      lat_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    disp_value = {1'b0, num2};
    case (state_q)
      ENTER_A: disp_value = {1'b0, num1};
      SHOW:    disp_value = res_q;
      default: disp_value = {1'b0, num2};
    endcase
  end

  assign suma_btn  = (state_q == START);
  assign busy      = (state_q == START) || (state_q == WAIT);
  assign res_valid = (state_q == SHOW);

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: stimulus queues expected sums, a monitor checks pulses and results.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W       = 12;
  localparam int ADD_LAT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         key_valid = 1'b0;
  logic [3:0]   key_code = 4'h0;
  logic [W:0]   resultado;
  logic [W-1:0] num1, num2;
  logic         suma_btn;
  logic [W:0]   disp_value;
  logic         busy, res_valid;

  always #5 clk = ~clk;

  calc_sequencer #(.W(W), .DIGITS(3), .ADD_LAT(ADD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .resultado  (resultado),
    .num1       (num1),
    .num2       (num2),
    .suma_btn   (suma_btn),
    .disp_value (disp_value),
    .busy       (busy),
    .res_valid  (res_valid)
  );

  // Adder model: sum is valid exactly ADD_LAT cycles after the start pulse, zero otherwise
  logic [W:0] pipe [ADD_LAT];
  logic       pv   [ADD_LAT];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ADD_LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0]   <= suma_btn;
      pipe[0] <= {1'b0, num1} + {1'b0, num2};
      for (int i = 1; i < ADD_LAT; i++) begin
        pv[i]   <= pv[i-1];
        pipe[i] <= pipe[i-1];
      end
    end
  end
  assign resultado = pv[ADD_LAT-1] ? pipe[ADD_LAT-1] : '0;

  typedef struct {
    int n1;
    int n2;
    int sum;
    bit abort;
  } exp_t;

  exp_t exp_q[$];
  exp_t pend;
  exp_t cur;
  bit   pend_valid = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   pulses = 0;
  int   exp_pulses = 0;
  int   cyc = 0;
  int   pulse_cyc = 0;
  bit   prev_suma = 1'b0;
  bit   prev_rv = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act == req) begin
      passed++;
      $display("check %s: %0d ok", name, act);
    end else begin
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: pops an expectation per start pulse, checks the captured sum on res_valid rise
  always @(negedge clk) begin
    cyc++;
    if (suma_btn) begin
      pulses++;
      if (prev_suma) chk("suma_btn one cycle wide", 1, 0);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected suma_btn: num1=%0d num2=%0d, required no pulse", num1, num2);
      end else if (!prev_suma) begin
        cur = exp_q.pop_front();
        chk("num1 at suma_btn", int'(num1), cur.n1);
        chk("num2 at suma_btn", int'(num2), cur.n2);
        pulse_cyc = cyc;
        if (!cur.abort) begin
          pend = cur;
          pend_valid = 1'b1;
        end
      end
    end
    if (res_valid && !prev_rv) begin
      if (!pend_valid) begin
        total++;
        $display("FAIL unexpected res_valid: disp_value=%0d, required no result", disp_value);
      end else begin
        chk("captured sum", int'(disp_value), pend.sum);
        chk("capture latency", cyc - pulse_cyc, ADD_LAT + 1);
        pend_valid = 1'b0;
      end
    end
    prev_suma = suma_btn;
    prev_rv   = res_valid;
  end

  // Called at a falling edge; the key is sampled at the following rising edge
  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic expect_sum(input int a, input int b, input int s, input bit abort);
    exp_t e;
    e.n1 = a;
    e.n2 = b;
    e.sum = s;
    e.abort = abort;
    exp_q.push_back(e);
    exp_pulses++;
  endtask

  task automatic wait_show(input string name);
    int n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (res_valid) passed++;
    else $display("FAIL %s: res_valid=0 after 20 cycles, required 1", name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset num1", int'(num1), 0);
    chk("reset num2", int'(num2), 0);
    chk("reset disp_value", int'(disp_value), 0);
    chk("reset suma_btn", int'(suma_btn), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset res_valid", int'(res_valid), 0);
    rst = 1'b1;
    @(negedge clk);

    // 123 + 45
    press(4'd1); press(4'd2); press(4'd3);
    chk("A entry disp 123", int'(disp_value), 123);
    press(4'hD);
    chk("code 0xD ignored", int'(disp_value), 123);
    press(KEY_EQ);
    chk("equals ignored in ENTER_A", int'(busy), 0);
    press(KEY_ADD);
    chk("disp cleared on add", int'(disp_value), 0);
    press(4'd4); press(4'd5);
    press(KEY_ADD);
    chk("add ignored in ENTER_B", int'(num2), 45);
    chk("B entry disp 45", int'(disp_value), 45);
    expect_sum(123, 45, 168, 1'b0);
    press(KEY_EQ);
    wait_show("sum 123+45");

    // digit limit: 999 + 999
    press(KEY_CLR);
    chk("clear from SHOW disp", int'(disp_value), 0);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9);
    chk("fourth digit ignored", int'(num1), 999);
    press(KEY_ADD);
    press(4'd9); press(4'd9); press(4'd9);
    expect_sum(999, 999, 1998, 1'b0);
    press(KEY_EQ);
    wait_show("sum 999+999");

    // empty B, extra equals ignored
    press(KEY_CLR);
    press(4'd5); press(KEY_ADD);
    expect_sum(5, 0, 5, 1'b0);
    press(KEY_EQ);
    wait_show("sum 5+0");
    press(KEY_EQ); press(KEY_EQ);
    repeat (5) @(negedge clk);
    chk("SHOW held after extra equals", int'(res_valid), 1);
    chk("result held 5", int'(disp_value), 5);
    press(4'd6);
    chk("digit in SHOW starts A", int'(num1), 6);
    chk("digit in SHOW leaves ENTER_A", int'(res_valid), 0);

    // clear during WAIT aborts, then normal operation resumes
    press(KEY_CLR);
    press(4'd7); press(KEY_ADD); press(4'd3);
    expect_sum(7, 3, 0, 1'b1);
    press(KEY_EQ);
    press(4'd8);
    chk("busy in WAIT", int'(busy), 1);
    press(KEY_CLR);
    chk("abort disp_value", int'(disp_value), 0);
    chk("abort num1", int'(num1), 0);
    chk("abort busy", int'(busy), 0);
    repeat (6) @(negedge clk);
    chk("no capture after abort", int'(res_valid), 0);
    press(4'd4); press(KEY_ADD); press(4'd4);
    expect_sum(4, 4, 8, 1'b0);
    press(KEY_EQ);
    wait_show("sum 4+4");

    // asynchronous reset during WAIT
    press(KEY_CLR);
    press(4'd2); press(KEY_ADD); press(4'd3);
    expect_sum(2, 3, 0, 1'b1);
    press(KEY_EQ);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async reset busy", int'(busy), 0);
    chk("async reset num1", int'(num1), 0);
    chk("async reset num2", int'(num2), 0);
    chk("async reset disp_value", int'(disp_value), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("no capture after reset", int'(res_valid), 0);

    // chained add
    press(4'd1); press(4'd0); press(KEY_ADD); press(4'd2); press(4'd0);
    expect_sum(10, 20, 30, 1'b0);
    press(KEY_EQ);
    wait_show("sum 10+20");
    press(KEY_ADD);
`ifdef AUTO_CHAIN_EN
    press(4'd5);
    chk("chain num1 from result", int'(num1), 30);
    expect_sum(30, 5, 35, 1'b0);
    press(KEY_EQ);
    wait_show("sum 30+5");
`else
    chk("add ignored in SHOW", int'(res_valid), 1);
    press(4'd5);
    chk("new A after SHOW", int'(num1), 5);
    chk("new A disp", int'(disp_value), 5);
    press(KEY_EQ);
    repeat (6) @(negedge clk);
    chk("equals in ENTER_A starts nothing", int'(busy), 0);
`endif

    repeat (5) @(negedge clk);
    chk("start pulse count", pulses, exp_pulses);
    chk("outstanding expectations", exp_q.size() + int'(pend_valid), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
